// File: rtl/heart_logo_pkg.sv
// Shared types, colour defaults, heart mask table and logo geometry constants.
package heart_logo_pkg;

  typedef logic [11:0] rgb_t;

  localparam rgb_t HEART_COLOR_DEF = 12'hF00;
  localparam rgb_t RING_COLOR_DEF  = 12'hFFF;
  localparam rgb_t BG_COLOR_DEF    = 12'h000;

  // Row 0 is the top of the sprite; bit 15 of each row is column 0.
  localparam logic [15:0] HEART_MASK [16] = '{
    16'h0000, 16'h0000, 16'h1C38, 16'h3E7C,
    16'h7FFE, 16'h7FFE, 16'h7FFE, 16'h7FFE,
    16'h3FFC, 16'h1FF8, 16'h0FF0, 16'h07E0,
    16'h03C0, 16'h0180, 16'h0000, 16'h0000
  };

  // Scaled-heart zone in logo coordinates, inclusive on both ends.
  localparam logic [6:0] ZONE_LO = 7'd32;
  localparam logic [6:0] ZONE_HI = 7'd95;

  // Ring radius-squared window around (64,64): radius 52..60 inclusive.
  localparam logic [13:0] RING_D2_MIN = 14'd2704;
  localparam logic [13:0] RING_D2_MAX = 14'd3600;

  // Distance of a 7-bit coordinate from the logo centre, always 0..64.
  function automatic logic [6:0] centre_dist(input logic [6:0] c);
    return (c >= 7'd64) ? (c - 7'd64) : (7'd64 - c);
  endfunction

endpackage

// File: rtl/heart_logo_if.sv
// Pixel address/colour bundle for the two independent sprite ports.
// There is no valid/ready pair: an address is taken on every rising clk edge
// and its colour appears on the matching rgb signal after that edge; the
// port can never stall.
interface heart_logo_if;
  import heart_logo_pkg::*;

  logic [3:0] heart_x;
  logic [3:0] heart_y;
  rgb_t       heart_rgb;
  logic [6:0] logo_x;
  logic [6:0] logo_y;
  rgb_t       logo_rgb;

  modport master (
    output heart_x, heart_y, logo_x, logo_y,
    input  heart_rgb, logo_rgb
  );

  modport slave (
    input  heart_x, heart_y, logo_x, logo_y,
    output heart_rgb, logo_rgb
  );

endinterface

// File: rtl/heart_mask_lookup.sv
// Combinational lookup of one heart mask bit at (column, row).
module heart_mask_lookup
  import heart_logo_pkg::*;
(
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  output logic       o_lit
);

  // Column 0 maps to bit 15, so the bit index is mirrored.
  assign o_lit = HEART_MASK[i_y][4'd15 - i_x];

endmodule

// File: rtl/heart_logo.sv
// Two registered sprite ROM ports: a 16x16 heart and a 128x128 logo made of
// a 4x scaled heart inside a ring.
module heart_logo
  import heart_logo_pkg::*;
#(
  parameter rgb_t HEART_COLOR = HEART_COLOR_DEF,
  parameter rgb_t RING_COLOR  = RING_COLOR_DEF,
  parameter rgb_t BG_COLOR    = BG_COLOR_DEF
) (
  input  logic         clk,
  input  logic         reset,
  heart_logo_if.slave  bus
);

  logic       w_heart_lit;
  logic       w_logo_lit;
  logic       w_in_zone;
  logic       w_in_ring;
  logic [3:0] w_logo_col;
  logic [3:0] w_logo_row;
  logic [6:0] w_adx;
  logic [6:0] w_ady;
  logic [13:0] w_d2;
  rgb_t       w_heart_next;
  rgb_t       w_logo_next;
  rgb_t       r_heart_rgb;
  rgb_t       r_logo_rgb;

  heart_mask_lookup u_heart_lookup (
    .i_x   (bus.heart_x),
    .i_y   (bus.heart_y),
    .o_lit (w_heart_lit)
  );

  // Outside the zone these indices are meaningless but harmless: w_in_zone gates them.
  assign w_logo_col = 4'((bus.logo_x - ZONE_LO) >> 2);
  assign w_logo_row = 4'((bus.logo_y - ZONE_LO) >> 2);

  heart_mask_lookup u_logo_lookup (
    .i_x   (w_logo_col),
    .i_y   (w_logo_row),
    .o_lit (w_logo_lit)
  );

  // |dx|,|dy| squared equals dx*dx, dy*dy; max sum is 64^2+64^2 = 8192.
  assign w_adx = centre_dist(bus.logo_x);
  assign w_ady = centre_dist(bus.logo_y);
  assign w_d2  = (14'(w_adx) * 14'(w_adx)) + (14'(w_ady) * 14'(w_ady));

  assign w_in_zone = (bus.logo_x >= ZONE_LO) && (bus.logo_x <= ZONE_HI) &&
                     (bus.logo_y >= ZONE_LO) && (bus.logo_y <= ZONE_HI);
  assign w_in_ring = (w_d2 >= RING_D2_MIN) && (w_d2 <= RING_D2_MAX);

  // Colour selection; the scaled heart takes priority over the ring.
  always_comb begin
    w_heart_next = w_heart_lit ? HEART_COLOR : BG_COLOR;
    w_logo_next  = BG_COLOR;
    if (w_in_zone && w_logo_lit) begin
      w_logo_next = HEART_COLOR;
    end else if (w_in_ring) begin
      w_logo_next = RING_COLOR;
    end
  end

  // Output registers; reset clears them at once, with no clock needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_heart_rgb <= 12'h000;
      r_logo_rgb  <= 12'h000;
    end else begin
      r_heart_rgb <= w_heart_next;
      r_logo_rgb  <= w_logo_next;
    end
  end

  assign bus.heart_rgb = r_heart_rgb;
  assign bus.logo_rgb  = r_logo_rgb;

endmodule

// File: tb/tb_heart_logo.sv
// Directed bench for heart_logo: reset behaviour, single lookups, ring
// boundaries and a back-to-back stream on both ports.
module tb_heart_logo;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  heart_logo_if bus ();

  heart_logo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed stream vectors: heart (x,y,expected)
  logic [3:0]  hx [16] = '{4'd7, 4'd0, 4'd15, 4'd7, 4'd3, 4'd6, 4'd1, 4'd14,
                           4'd0, 4'd8, 4'd5, 4'd9, 4'd10, 4'd15, 4'd2, 4'd7};
  logic [3:0]  hy [16] = '{4'd5, 4'd0, 4'd4, 4'd13, 4'd2, 4'd2, 4'd4, 4'd7,
                           4'd7, 4'd12, 4'd12, 4'd13, 4'd11, 4'd15, 4'd3, 4'd3};
  logic [11:0] he [16] = '{12'hF00, 12'h000, 12'h000, 12'hF00, 12'hF00, 12'h000, 12'hF00, 12'hF00,
                           12'h000, 12'hF00, 12'h000, 12'h000, 12'hF00, 12'h000, 12'hF00, 12'h000};
  // Logo (x,y,expected)
  logic [6:0]  lx [16] = '{7'd64, 7'd32, 7'd64, 7'd64, 7'd64, 7'd0, 7'd64, 7'd64,
                           7'd124, 7'd125, 7'd40, 7'd33, 7'd104, 7'd95, 7'd36, 7'd127};
  logic [6:0]  ly [16] = '{7'd64, 7'd32, 7'd8, 7'd4, 7'd3, 7'd0, 7'd12, 7'd13,
                           7'd64, 7'd64, 7'd48, 7'd48, 7'd104, 7'd64, 7'd56, 7'd127};
  logic [11:0] le [16] = '{12'hF00, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000,
                           12'hFFF, 12'h000, 12'hF00, 12'h000, 12'hFFF, 12'h000, 12'hF00, 12'h000};

  // Scoreboard check
  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: present addresses on both ports
  task automatic drive(input logic [3:0] x, input logic [3:0] y,
                       input logic [6:0] x7, input logic [6:0] y7);
    bus.heart_x = x;
    bus.heart_y = y;
    bus.logo_x  = x7;
    bus.logo_y  = y7;
  endtask

  // Driver: present one address pair at negedge, check one edge later
  task automatic step(input string tag,
                      input logic [3:0] x, input logic [3:0] y, input logic [11:0] eh,
                      input logic [6:0] x7, input logic [6:0] y7, input logic [11:0] el);
    @(negedge clk);
    drive(x, y, x7, y7);
    @(posedge clk);
    #1;
    check({tag, "_heart"}, bus.heart_rgb, eh);
    check({tag, "_logo"},  bus.logo_rgb,  el);
  endtask

  logic [11:0] prev_h;
  logic [11:0] prev_l;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(4'd7, 4'd5, 7'd64, 7'd64);

    // Reset held with addresses changing: outputs stay clear
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(hx[i], hy[i], lx[i], ly[i]);
      @(posedge clk);
      #1;
      check("reset_hold_heart", bus.heart_rgb, 12'h000);
      check("reset_hold_logo",  bus.logo_rgb,  12'h000);
    end

    // Release reset; first edge gives valid data
    @(negedge clk);
    reset = 1'b0;
    drive(4'd7, 4'd5, 7'd64, 7'd8);
    @(posedge clk);
    #1;
    check("first_edge_heart", bus.heart_rgb, 12'hF00);
    check("first_edge_logo",  bus.logo_rgb,  12'hFFF);

    // Directed single lookups
    step("h75_l6464",   4'd7,  4'd5,  12'hF00, 7'd64, 7'd64, 12'hF00);
    step("h00_l3232",   4'd0,  4'd0,  12'h000, 7'd32, 7'd32, 12'h000);
    step("h154_l648",   4'd15, 4'd4,  12'h000, 7'd64, 7'd8,  12'hFFF);
    step("h713_l644",   4'd7,  4'd13, 12'hF00, 7'd64, 7'd4,  12'hFFF);
    step("h75_l643",    4'd7,  4'd5,  12'hF00, 7'd64, 7'd3,  12'h000);
    step("h00_l00",     4'd0,  4'd0,  12'h000, 7'd0,  7'd0,  12'h000);
    step("ring_in_min", 4'd0,  4'd0,  12'h000, 7'd116, 7'd64, 12'hFFF);
    step("ring_below",  4'd0,  4'd0,  12'h000, 7'd64, 7'd13, 12'h000);
    step("zone_edge",   4'd0,  4'd0,  12'h000, 7'd35, 7'd56, 12'h000);

    // Stream: new pair every cycle; output must hold until the next edge
    prev_h = 12'h000;
    prev_l = 12'h000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(hx[i], hy[i], lx[(i + 5) % 16], ly[(i + 5) % 16]);
      #1;
      check("stream_hold_heart", bus.heart_rgb, prev_h);
      check("stream_hold_logo",  bus.logo_rgb,  prev_l);
      @(posedge clk);
      #1;
      check("stream_heart", bus.heart_rgb, he[i]);
      check("stream_logo",  bus.logo_rgb,  le[(i + 5) % 16]);
      prev_h = he[i];
      prev_l = le[(i + 5) % 16];
    end

    // Mid-stream reset clears the outputs between edges
    step("pre_reset", 4'd7, 4'd5, 12'hF00, 7'd64, 7'd8, 12'hFFF);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_heart", bus.heart_rgb, 12'h000);
    check("async_reset_logo",  bus.logo_rgb,  12'h000);
    @(posedge clk);
    #1;
    check("reset_edge_heart", bus.heart_rgb, 12'h000);
    check("reset_edge_logo",  bus.logo_rgb,  12'h000);
    @(negedge clk);
    reset = 1'b0;
    drive(4'd8, 4'd12, 7'd40, 7'd48);
    @(posedge clk);
    #1;
    check("after_reset_heart", bus.heart_rgb, 12'hF00);
    check("after_reset_logo",  bus.logo_rgb,  12'hF00);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/heart_logo.md
HEART_LOGO -- requirements
Module: heart_logo

Interface
REQ-001 SHALL have parameter HEART_COLOR, default 12'hF00, the 12-bit RGB colour of lit heart pixels.
REQ-002 SHALL have parameter RING_COLOR, default 12'hFFF, the RGB colour of the logo ring.
REQ-003 SHALL have parameter BG_COLOR, default 12'h000, the RGB colour of every unlit pixel.
REQ-004 clk  input  1  rising-edge clock for all registers.
REQ-005 reset  input  1  reset, asynchronous, active-high; clock clk.
REQ-006 heart_x  input  4  column of the heart sprite, 0 = leftmost.
REQ-007 heart_y  input  4  row of the heart sprite, 0 = top.
REQ-008 heart_rgb  output  12  registered heart pixel colour, format {R[3:0],G[3:0],B[3:0]}.
REQ-009 logo_x  input  7  column of the logo sprite, 0..127.
REQ-010 logo_y  input  7  row of the logo sprite, 0..127.
REQ-011 logo_rgb  output  12  registered logo pixel colour.

Function
REQ-012 The heart mask SHALL be 16 rows of 16 bits, rows 0..15 in hex: 0000, 0000, 1C38, 3E7C, 7FFE, 7FFE, 7FFE, 7FFE, 3FFC, 1FF8, 0FF0, 07E0, 03C0, 0180, 0000, 0000.
REQ-013 Mask bit 15 SHALL be column 0 and bit 0 SHALL be column 15.
REQ-014 heart_rgb SHALL load HEART_COLOR when mask(heart_x, heart_y) = 1, and BG_COLOR otherwise.
REQ-015 The logo SHALL use signed offsets dx = logo_x-64 and dy = logo_y-64, and d2 = dx*dx+dy*dy with at least 14-bit unsigned width (max 8192).
REQ-016 The logo heart zone SHALL be logo_x in 32..95 and logo_y in 32..95.
REQ-017 Inside the heart zone, the heart mask SHALL be sampled at column (logo_x-32)>>2 and row (logo_y-32)>>2, giving a 4x scaled heart.
REQ-018 The logo pixel SHALL take HEART_COLOR when it is in the heart zone and the sampled mask bit is 1.
REQ-019 Otherwise the logo pixel SHALL take RING_COLOR when 2704 <= d2 <= 3600 (radius 52..60, both bounds inclusive).
REQ-020 Otherwise the logo pixel SHALL take BG_COLOR.
REQ-021 Each output SHALL be registered with exactly one clk cycle of latency from its address inputs.
REQ-022 A new address SHALL be accepted every cycle, with no handshake and no stall.
REQ-023 The two ports SHALL be fully independent; simultaneous accesses SHALL NOT interfere with each other.
REQ-024 All address values SHALL be valid; coordinate wrap-around is the caller's responsibility.

Reset
REQ-025 While reset = 1, heart_rgb and logo_rgb SHALL be 12'h000 immediately, without waiting for a clock edge.
REQ-026 After reset deasserts, the first rising edge of clk SHALL produce valid data for the addresses presented at that edge.
REQ-027 Reset asserted mid-stream SHALL discard the pending output, with no other retained state.

Structure
REQ-028 The heart mask table and the colour defaults SHALL live in a shared package, heart_logo_pkg.
REQ-029 The ring radius-squared bounds 2704 and 3600 and the zone limits 32 and 95 SHALL be package constants.
REQ-030 One combinational sub-module, heart_mask_lookup (4-bit x, 4-bit y in; 1-bit lit out), SHALL be instantiated twice: once for the heart port and once for the logo port.

Verification
REQ-031 Assert reset with addresses changing -> heart_rgb = logo_rgb = 12'h000 asynchronously; first edge after release gives valid data.
REQ-032 heart (7,5) -> 12'hF00 one cycle later; heart (0,0) -> 12'h000; heart (15,4) -> 12'h000; heart (7,13) -> 12'hF00.
REQ-033 logo (64,64) -> 12'hF00 (mask row 8, column 8 lit); logo (32,32) -> 12'h000 (mask row 0 unlit, d2 = 2048).
REQ-034 logo (64,8) -> 12'hFFF (d2 = 3136); logo (64,4) -> 12'hFFF (d2 = 3600); logo (64,3) -> 12'h000 (d2 = 3721); logo (0,0) -> 12'h000.
REQ-035 Stream a new address every cycle on both ports simultaneously -> each output matches the per-address value exactly one cycle later, with no cross-port effect.
